// File: rtl/esaxi_emesh_arbiter.sv
// ---------------------------------------------------------------------------
// esaxi_emesh_arbiter
//
// Shares one emesh transmit port between the AXI slave write path and its
// read-request path. Arbitration is a weighted round-robin:
//   - A write may win up to WR_WEIGHT ties in a row.
//   - After that, a pending read takes the next tie.
// The winner is captured in a single registered output stage, and that
// stage honours downstream back-pressure (tx_wait).
//
// Parameters
//   PW         emesh packet width in bits.
//   WR_WEIGHT  maximum consecutive write grants while a read is pending.
//              The legal range is 1..15.
//
// Ports
//   s_axi_aclk     clock; everything is on the rising edge.
//   s_axi_aresetn  synchronous active-low reset.
//   wr_access/wr_packet/wr_wait  write source handshake.
//                  wr_wait=1 means the packet was not taken this cycle.
//   rd_access/rd_packet/rd_wait  read-request source handshake.
//   tx_access/tx_packet          registered output packet.
//   tx_wait                      downstream stall.
//
// Optional build macro: ESAXI_ARB_STATS_EN
//   Adds the ports stat_clr, stat_wr_cnt and stat_rd_cnt.
//   stat_wr_cnt and stat_rd_cnt are saturating 32-bit counts of accepted
//   transfers. stat_clr clears both counts and wins over a same-cycle
//   increment.
// ---------------------------------------------------------------------------
module esaxi_emesh_arbiter #(
  parameter int PW        = 104,
  parameter int WR_WEIGHT = 1
) (
  input  logic          s_axi_aclk,
  input  logic          s_axi_aresetn,
  input  logic          wr_access,
  input  logic [PW-1:0] wr_packet,
  output logic          wr_wait,
  input  logic          rd_access,
  input  logic [PW-1:0] rd_packet,
  output logic          rd_wait,
`ifdef ESAXI_ARB_STATS_EN
  input  logic          stat_clr,
  output logic [31:0]   stat_wr_cnt,
  output logic [31:0]   stat_rd_cnt,
`endif
  output logic          tx_access,
  output logic [PW-1:0] tx_packet,
  input  logic          tx_wait
);

  // Weight as a 4-bit constant, so it compares directly with wr_cnt.
  localparam logic [3:0] WR_WEIGHT_C = 4'(WR_WEIGHT);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

  // Round-robin memory: which source won the most recent accepted transfer.
  typedef enum logic {
    LAST_RD = 1'b0,
    LAST_WR = 1'b1
  } last_e;

  logic          tx_access_q,  tx_access_d;
  logic [PW-1:0] tx_packet_q,  tx_packet_d;
  last_e         last_grant_q, last_grant_d;
  logic [3:0]    wr_cnt_q,     wr_cnt_d;

  logic out_free;
  gnt_e gnt;
  logic wr_fire;
  logic rd_fire;

  // -------------------------------------------------------------------------
  // Grant selection and source handshake.
  // These depend only on the access bits, tx_wait and local state.
  // There is no combinational path from either packet to a wait output.
  // -------------------------------------------------------------------------
  always_comb begin
    // The stage can load when it is empty, or when its packet retires now.
    out_free = !tx_access_q || !tx_wait;

    gnt = GNT_NONE;
    if (wr_access && rd_access) begin
      if (last_grant_q == LAST_RD || wr_cnt_q < WR_WEIGHT_C) begin
        gnt = GNT_WR;
      end else begin
        gnt = GNT_RD;
      end
    end else if (wr_access) begin
      gnt = GNT_WR;
    end else if (rd_access) begin
      gnt = GNT_RD;
    end

    // A grant is only issued to an asserting source, so a fire implies an
    // access.
    wr_fire = out_free && (gnt == GNT_WR);
    rd_fire = out_free && (gnt == GNT_RD);
  end

  assign wr_wait = wr_access && !wr_fire;
  assign rd_wait = rd_access && !rd_fire;

  // -------------------------------------------------------------------------
  // Next-state logic for the output stage and the round-robin state.
  // -------------------------------------------------------------------------
  always_comb begin
    tx_access_d  = tx_access_q;
    tx_packet_d  = tx_packet_q;
    last_grant_d = last_grant_q;
    wr_cnt_d     = wr_cnt_q;

    if (out_free) begin
      // An idle cycle clears the valid bit but keeps the last packet value.
      tx_access_d = wr_fire || rd_fire;
      if (wr_fire) begin
        tx_packet_d = wr_packet;
      end else if (rd_fire) begin
        tx_packet_d = rd_packet;
      end
    end

    if (wr_fire) begin
      // Count consecutive write wins.
      // The count restarts at 1 when the previous winner was a read.
      if (last_grant_q == LAST_WR) begin
        wr_cnt_d = (wr_cnt_q == 4'hF) ? 4'hF : wr_cnt_q + 4'd1;
      end else begin
        wr_cnt_d = 4'd1;
      end
      last_grant_d = LAST_WR;
    end else if (rd_fire) begin
      wr_cnt_d     = 4'd0;
      last_grant_d = LAST_RD;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      tx_access_q  <= 1'b0;
      tx_packet_q  <= '0;
      // Starting from "read won last" lets a write win the first tie.
      last_grant_q <= LAST_RD;
      wr_cnt_q     <= 4'd0;
    end else begin
      tx_access_q  <= tx_access_d;
      tx_packet_q  <= tx_packet_d;
      last_grant_q <= last_grant_d;
      wr_cnt_q     <= wr_cnt_d;
    end
  end

  assign tx_access = tx_access_q;
  assign tx_packet = tx_packet_q;

`ifdef ESAXI_ARB_STATS_EN
  // -------------------------------------------------------------------------
  // Transfer statistics. Each counter saturates at all-ones.
  // -------------------------------------------------------------------------
  logic [31:0] stat_wr_q, stat_wr_d;
  logic [31:0] stat_rd_q, stat_rd_d;

  always_comb begin
    stat_wr_d = stat_wr_q;
    stat_rd_d = stat_rd_q;
    if (stat_clr) begin
      stat_wr_d = '0;
      stat_rd_d = '0;
    end else begin
      if (wr_fire && stat_wr_q != 32'hFFFF_FFFF) begin
        stat_wr_d = stat_wr_q + 32'd1;
      end
      if (rd_fire && stat_rd_q != 32'hFFFF_FFFF) begin
        stat_rd_d = stat_rd_q + 32'd1;
      end
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      stat_wr_q <= '0;
      stat_rd_q <= '0;
    end else begin
      stat_wr_q <= stat_wr_d;
      stat_rd_q <= stat_rd_d;
    end
  end

  assign stat_wr_cnt = stat_wr_q;
  assign stat_rd_cnt = stat_rd_q;
`endif

endmodule

// File: tb/tb_esaxi_emesh_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for esaxi_emesh_arbiter.
//
// Two instances run side by side, one with WR_WEIGHT=1 and one with
// WR_WEIGHT=3. Each instance has its own randomised sources and its own
// reference model.
//
// The model decides which source is accepted on each cycle. When a source
// is accepted, the model pushes the expected packet, together with the
// cycle it is due to appear, into a queue. A separate monitor compares
// tx_access/tx_packet against the head of that queue.
// ---------------------------------------------------------------------------
module tb_esaxi_emesh_arbiter;
  localparam int PW = 104;
  localparam int NI = 2;

  typedef struct {
    logic [PW-1:0] pkt;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   done [NI];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int inst,
                       input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h exp=%0h",
               name, inst, cyc, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] rnd_pkt();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[PW-1:0];
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int W = (gi == 0) ? 1 : 3;

    logic          wa, ra, ww, rw, ta, tw;
    logic [PW-1:0] wp, rp, tp;
    exp_t          q[$];
`ifdef ESAXI_ARB_STATS_EN
    logic          sc;
    logic [31:0]   swc, src;
`endif

    esaxi_emesh_arbiter #(.PW(PW), .WR_WEIGHT(W)) u_dut (
      .s_axi_aclk   (clk),
      .s_axi_aresetn(rstn),
      .wr_access    (wa),
      .wr_packet    (wp),
      .wr_wait      (ww),
      .rd_access    (ra),
      .rd_packet    (rp),
      .rd_wait      (rw),
`ifdef ESAXI_ARB_STATS_EN
      .stat_clr     (sc),
      .stat_wr_cnt  (swc),
      .stat_rd_cnt  (src),
`endif
      .tx_access    (ta),
      .tx_packet    (tp),
      .tx_wait      (tw)
    );

    // Reference model state.
    //   m_held    : the output stage holds a packet.
    //   m_last_rd : the most recent winner was a read.
    //   m_wcnt    : consecutive write wins (unbounded).
    bit m_held, m_last_rd;
    int m_wcnt, n_wr, n_rd;
    bit acc_w, acc_r, dut_acc_w;

    // One clock cycle:
    //   - At the falling edge, the model decides the acceptances, checks
    //     both wait outputs and queues any accepted packet.
    //   - The task returns 1 time unit after the next rising edge.
    task automatic run_cycle();
      bit out_free, gw, gr;
      @(negedge clk);
      out_free = !m_held || !tw;
      gw = 1'b0;
      gr = 1'b0;
      if (wa && ra) begin
        if (m_last_rd || m_wcnt < W) gw = 1'b1; else gr = 1'b1;
      end else if (wa) begin
        gw = 1'b1;
      end else if (ra) begin
        gr = 1'b1;
      end
      acc_w = gw && out_free;
      acc_r = gr && out_free;
      dut_acc_w = wa && !ww;
      check("wr_wait", gi, PW'(ww), PW'(wa && !acc_w));
      check("rd_wait", gi, PW'(rw), PW'(ra && !acc_r));
      if (acc_w) begin
        q.push_back('{wp, cyc + 1});
        m_wcnt    = m_last_rd ? 1 : m_wcnt + 1;
        m_last_rd = 1'b0;
        n_wr++;
      end
      if (acc_r) begin
        q.push_back('{rp, cyc + 1});
        m_wcnt    = 0;
        m_last_rd = 1'b1;
        n_rd++;
      end
      if (out_free) m_held = gw || gr;
      @(posedge clk);
      #1;
    endtask

    // Choose the next inputs.
    // A source whose packet was not accepted keeps its access and packet.
    task automatic next_inputs(input int pw_pct, input int pr_pct,
                               input int tw_pct);
      if (!(wa && !acc_w)) begin
        wa = ($urandom_range(99) < pw_pct);
        wp = rnd_pkt();
      end
      if (!(ra && !acc_r)) begin
        ra = ($urandom_range(99) < pr_pct);
        rp = rnd_pkt();
      end
      tw = ($urandom_range(99) < tw_pct);
    endtask

    // Monitor: compares the registered output against the expected queue.
    always @(negedge clk) begin
      if (rstn) begin
        if (ta) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL tx_spurious inst=%0d cyc=%0d got=%0h exp=none",
                     gi, cyc, tp);
          end else if (q[0].due > cyc || tp !== q[0].pkt) begin
            failures++;
            $display("FAIL tx_packet inst=%0d cyc=%0d got=%0h exp=%0h due=%0d",
                     gi, cyc, tp, q[0].pkt, q[0].due);
            if (!tw) void'(q.pop_front());
          end else if (!tw) begin
            void'(q.pop_front());
          end
        end else if (q.size() != 0) begin
          checks++;
          if (q[0].due <= cyc) begin
            failures++;
            $display("FAIL tx_missing inst=%0d cyc=%0d got=idle exp=%0h",
                     gi, cyc, q[0].pkt);
            void'(q.pop_front());
          end
        end
      end
    end

    initial begin
      logic [PW-1:0] p55;
      p55       = 'h55;
      m_held    = 1'b0;
      m_last_rd = 1'b1;
      m_wcnt    = 0;
      n_wr      = 0;
      n_rd      = 0;
      acc_w     = 1'b0;
      acc_r     = 1'b0;
      // Both sources request while reset is held.
      wa = 1'b1; wp = 'hA;
      ra = 1'b1; rp = 'hB;
      tw = 1'b0;
`ifdef ESAXI_ARB_STATS_EN
      sc = 1'b0;
`endif
      @(negedge clk);
      @(negedge clk);
      check("reset_tx_access", gi, PW'(ta), '0);
      check("reset_tx_packet", gi, tp, '0);
      wait (rstn);

      // Both sources stream with no back-pressure.
      // Acceptance n must be a write exactly when n mod (W+1) < W.
      for (int n = 0; n < 16; n++) begin
        run_cycle();
        check("wrr_order", gi, PW'(dut_acc_w), PW'((n % (W + 1)) < W));
        if (n == 0) check("first_tie_pkt", gi, tp, 'hA);
        next_inputs(100, 100, 0);
      end
      for (int n = 0; n < 4; n++) begin
        run_cycle();
        next_inputs(0, 0, 0);
      end

      // Load 0x55 from the write source.
      // Then stall for 4 cycles while a read waits.
      wa = 1'b1; wp = p55; ra = 1'b0; tw = 1'b0;
      run_cycle();
      wa = 1'b0; ra = 1'b1; rp = rnd_pkt(); tw = 1'b1;
      for (int n = 0; n < 4; n++) begin
        run_cycle();
        check("stall_hold_pkt", gi, tp, p55);
      end
      tw = 1'b0;
      run_cycle();
      check("after_stall_pkt", gi, tp, rp);
      ra = 1'b0;
      run_cycle();

      // Single-cycle read pulse, then a tie, which the write must win.
      for (int n = 0; n < 2; n++) run_cycle();
      ra = 1'b1; rp = rnd_pkt();
      run_cycle();
      ra = 1'b0;
      run_cycle();
      run_cycle();
      wa = 1'b1; wp = rnd_pkt(); ra = 1'b1; rp = rnd_pkt();
      run_cycle();
      check("tie_after_rd", gi, PW'(dut_acc_w), PW'(1));
      for (int n = 0; n < 4; n++) begin
        next_inputs(0, 0, 0);
        run_cycle();
      end

`ifdef ESAXI_ARB_STATS_EN
      check("stat_wr_cnt", gi, PW'(swc), PW'(n_wr));
      check("stat_rd_cnt", gi, PW'(src), PW'(n_rd));
      // Clear together with an accepted write: the clear wins.
      wa = 1'b1; wp = rnd_pkt(); sc = 1'b1;
      run_cycle();
      check("stat_clr_wr", gi, PW'(swc), '0);
      check("stat_clr_rd", gi, PW'(src), '0);
      sc = 1'b0; wa = 1'b0; n_wr = 0; n_rd = 0;
      run_cycle();
`endif

      // Random traffic with random back-pressure.
      for (int n = 0; n < 300; n++) begin
        next_inputs(60, 50, 30);
        run_cycle();
      end
      for (int n = 0; n < 6; n++) begin
        next_inputs(0, 0, 0);
        run_cycle();
      end
      check("queue_drained", gi, PW'(q.size()), '0);
`ifdef ESAXI_ARB_STATS_EN
      check("stat_wr_final", gi, PW'(swc), PW'(n_wr));
      check("stat_rd_final", gi, PW'(src), PW'(n_rd));
`endif
      done[gi] = 1'b1;
    end
  end

  initial begin
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    wait (done[0] && done[1]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog got=timeout exp=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/esaxi_emesh_arbiter.md
Name: esaxi_emesh_arbiter

Overview:
- Shares one emesh transmit port between the write path (wr_access/wr_packet/wr_wait) and the read-request path (rd_access/rd_packet/rd_wait) of the AXI slave.
- Uses weighted round-robin arbitration.
- The output is registered in a single-entry stage and honours downstream back-pressure.
- Sits between the AXI slave's emesh outputs and the fabric transmit interface.

Parameters:
- PW, 104, emesh packet width in bits.
- WR_WEIGHT, 1, maximum consecutive write grants while a read is pending (range 1..15).

Ports:
- s_axi_aclk  input  1  clock; all logic on the rising edge.
- s_axi_aresetn  input  1  reset, synchronous, active-low.
- wr_access  input  1  write packet valid.
- wr_packet  input  PW  write packet.
- wr_wait  output  1  stall to write source; packet not accepted this cycle.
- rd_access  input  1  read-request packet valid.
- rd_packet  input  PW  read-request packet.
- rd_wait  output  1  stall to read source.
- tx_access  output  1  output packet valid (registered).
- tx_packet  output  PW  output packet (registered).
- tx_wait  input  1  downstream stall.

Behaviour:
- Reset (s_axi_aresetn=0 at clock edge):
  - tx_access=0, tx_packet=0.
  - last_grant=RD, so a write wins the first tie.
  - wr_cnt=0.
  - Reset mid-operation drops any held packet; sources are reset alongside.
- out_free = !tx_access || !tx_wait. The output stage can load this cycle when out_free is 1.
- Source handshake: the source holds access and packet stable while its wait is 1. A packet transfers on a cycle where access=1 and wait=0.
- Grant selection (combinational, evaluated every cycle):
  - Only one access asserted: grant that source.
  - Both asserted, last_grant=RD: grant WR.
  - Both asserted, last_grant=WR and wr_cnt<WR_WEIGHT: grant WR.
  - Both asserted, last_grant=WR and wr_cnt>=WR_WEIGHT: grant RD.
  - Neither asserted: no grant.
- Wait outputs:
  - wr_wait = wr_access & !(out_free & gnt==WR).
  - rd_wait = rd_access & !(out_free & gnt==RD).
  - Both are 0 when the corresponding access is 0.
  - Outputs are combinational from inputs and state, with no comb path from packet to wait.
- Output stage, on a clock edge with out_free=1:
  - With a grant: tx_access<=1 and tx_packet<=granted packet. Latency from accepted input to tx_access is 1 cycle.
  - Without a grant: tx_access<=0 and tx_packet holds its value.
- With tx_access=1 and tx_wait=1: tx_access and tx_packet hold unchanged, both sources see wait=1, and grant state does not advance.
- State update, only on an accepted transfer:
  - WR accepted: wr_cnt <= (last_grant==WR) ? sat(wr_cnt+1) : 1, and last_grant<=WR.
  - RD accepted: wr_cnt<=0, last_grant<=RD.
  - wr_cnt is 4 bits and saturates at 15.
- Throughput: one packet per cycle with tx_wait=0, including back-to-back alternation.
- tx_wait rising while tx_access=0 has no effect; the stage loads, then holds on the next cycle.
- Simultaneous tx_wait falling and new requests: the held packet retires and a new grant loads on the same edge.

Optional Feature:
- Macro: ESAXI_ARB_STATS_EN.
- When defined, the block adds these ports:
  - stat_clr input 1.
  - stat_wr_cnt output 32.
  - stat_rd_cnt output 32.
- Counter behaviour when defined:
  - Each counter increments by 1 per accepted WR or RD transfer and saturates at 0xFFFFFFFF.
  - Both counters reset to 0 on reset.
  - stat_clr=1 clears both to 0 on that edge; clear has priority over a same-cycle increment.
- When undefined: the ports and counters are absent and arbitration behaviour is identical.

Test Plan:
- Reset with both access=1 and packets 0xA/0xB, then release reset.
  - Cycle 0: wr_wait=0, rd_wait=1.
  - Next cycle: tx_packet=0xA, tx_access=1.
- WR_WEIGHT=1, both sources streaming, tx_wait=0.
  - tx_packet order is WR,RD,WR,RD…, one per cycle.
- WR_WEIGHT=3, both streaming.
  - Order is WR,WR,WR,RD repeating; wr_cnt saturation is never reached.
- Load packet 0x55 from WR, then hold tx_wait=1 for 4 cycles while rd_access=1.
  - tx_packet stays 0x55 and rd_wait=1 throughout.
  - The cycle after tx_wait falls, tx_packet equals the RD packet.
- Only rd_access pulsed for a single cycle with tx_wait=0.
  - rd_wait=0 on that cycle; tx_access is 1 for exactly one cycle.
  - last_grant=RD, so the next tie grants WR.
- ESAXI_ARB_STATS_EN defined: 5 WR and 3 RD transfers.
  - stat_wr_cnt=5, stat_rd_cnt=3.
  - stat_clr asserted alongside a WR accept gives stat_wr_cnt=0 after that edge.
